// File: rtl/uart_cmd_sched.sv
// Queues host commands and issues them one at a time to a UART, returning read data or a read timeout.
// uart_cmd_vld rises 2 cycles after a push into an empty queue; host_rdy drops while the queue is full.
module uart_cmd_sched #(
    parameter int CMD_WIDTH  = 16,
    parameter int READ_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CMD_WIDTH-1:0]        host_cmd,
    input  logic                        host_vld,
    output logic                        host_rdy,
    output logic [CMD_WIDTH-1:0]        uart_cmd,
    output logic                        uart_cmd_vld,
    input  logic                        uart_cmd_rdy,
    input  logic                        uart_read_rdy,
    input  logic [READ_WIDTH:0]         uart_read_data,
    output logic [READ_WIDTH:0]         rsp_data,
    output logic                        rsp_vld,
    output logic                        rsp_timeout,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_LVL = FIFO_DEPTH[AW:0];
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, WAIT_RD} state_t;

    logic [CMD_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          level_q;
    logic                 push, pop, full, empty;
    logic [CMD_WIDTH-1:0] head;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 uart_cmd_vld_q, uart_cmd_vld_d;
    logic [READ_WIDTH:0]  rsp_data_q, rsp_data_d;
    logic                 rsp_vld_q, rsp_vld_d;
    logic                 rsp_timeout_q, rsp_timeout_d;

    assign full     = (level_q == FULL_LVL);
    assign empty    = (level_q == '0);
    assign host_rdy = !full && !rst_n;
    assign push     = host_vld && host_rdy;
    assign pop      = uart_cmd_vld_q && uart_cmd_rdy;
    assign head     = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= host_cmd;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_vld_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) state_d = ISSUE;
            end
            ISSUE: begin
                if (pop) begin
                    state_d = head[CMD_WIDTH-1] ? WAIT_RD : WAIT_DONE;
                    cnt_d   = '0;
                end
            end
            WAIT_DONE: begin
                if (uart_cmd_rdy) state_d = IDLE;
            end
            WAIT_RD: begin
                // Read data wins over a timeout landing in the same cycle.
                if (uart_read_rdy) begin
                    rsp_data_d = uart_read_data;
                    rsp_vld_d  = 1'b1;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Valid is registered, so it rises one cycle after ISSUE is entered and drops on the handshake edge.
        uart_cmd_vld_d = (state_q == ISSUE) && (state_d == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            uart_cmd_vld_q <= 1'b0;
            rsp_data_q     <= '0;
            rsp_vld_q      <= 1'b0;
            rsp_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            uart_cmd_vld_q <= uart_cmd_vld_d;
            rsp_data_q     <= rsp_data_d;
            rsp_vld_q      <= rsp_vld_d;
            rsp_timeout_q  <= rsp_timeout_d;
        end
    end

    assign uart_cmd     = uart_cmd_vld_q ? head : '0;
    assign uart_cmd_vld = uart_cmd_vld_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_vld      = rsp_vld_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign busy         = (state_q != IDLE);
    assign level        = level_q;

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Randomized bench for uart_cmd_sched with a transaction-level model of queue, issue order and responses.
module tb_uart_cmd_sched;
    localparam int T = 16;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] host_cmd;
    logic        host_vld, host_rdy;
    logic [15:0] uart_cmd;
    logic        uart_cmd_vld, uart_cmd_rdy, uart_read_rdy;
    logic [8:0]  uart_read_data, rsp_data;
    logic        rsp_vld, rsp_timeout, busy;
    logic [2:0]  level;

    always #5 clk = ~clk;

    uart_cmd_sched #(.CMD_WIDTH(16), .READ_WIDTH(8), .FIFO_DEPTH(D), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .host_cmd(host_cmd), .host_vld(host_vld), .host_rdy(host_rdy),
        .uart_cmd(uart_cmd), .uart_cmd_vld(uart_cmd_vld), .uart_cmd_rdy(uart_cmd_rdy),
        .uart_read_rdy(uart_read_rdy), .uart_read_data(uart_read_data), .rsp_data(rsp_data),
        .rsp_vld(rsp_vld), .rsp_timeout(rsp_timeout), .busy(busy), .level(level)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    logic [15:0] q[$];
    logic [15:0] issued[$];
    int          cnt;
    bit          rd_pend;
    int          rd_h, rd_k;
    logic [8:0]  rd_data;
    int          exp_vld_cyc, exp_to_cyc;
    logic [8:0]  exp_data, model_rsp;
    int          hold;
    bit          stall, rdy_rand, spur_en;
    int          rd_force;
    logic [8:0]  rd_force_data;
    bit          obs_vld_prev, pushed, obs_host_rdy, obs_busy;
    logic [2:0]  obs_level;
    int          last_vld_rise, last_push_edge;
    int          n_vld_pulse, n_to_pulse, n_vld_obs;

    // One cycle: check what the last edge produced, then drive inputs for the next edge and predict it.
    task automatic tick(input bit hv, input logic [15:0] hc);
        bit exp_v, exp_t, rdy, pop;
        logic [15:0] c;
        @(negedge clk);
        exp_v = (cyc == exp_vld_cyc);
        exp_t = (cyc == exp_to_cyc);
        chk("rsp_vld", rsp_vld, exp_v);
        chk("rsp_timeout", rsp_timeout, exp_t);
        if (exp_v) model_rsp = exp_data;
        chk("rsp_data", rsp_data, model_rsp);
        chk("level", level, cnt);
        chk("host_rdy", host_rdy, cnt < D);
        if (uart_cmd_vld) begin
            n_vld_obs++;
            chk("vld_nonempty", q.size() > 0, 1);
            if (q.size() > 0) chk("uart_cmd", uart_cmd, q[0]);
            if (!obs_vld_prev) last_vld_rise = cyc;
        end
        obs_vld_prev = uart_cmd_vld;
        if (rsp_vld) n_vld_pulse++;
        if (rsp_timeout) n_to_pulse++;
        obs_level = level;
        obs_host_rdy = host_rdy;
        obs_busy = busy;
        if (rd_pend && rd_k == 0 && cyc >= rd_h + T) rd_pend = 0;

        if (stall) rdy = 0;
        else if (hold > 0) begin rdy = 0; hold--; end
        else rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        uart_read_rdy = 1'b0;
        uart_read_data = 9'($urandom_range(0, 511));
        if (rd_pend && rd_k > 0 && cyc + 1 == rd_h + rd_k) begin
            uart_read_rdy = 1'b1;
            uart_read_data = rd_data;
            exp_vld_cyc = cyc + 1;
            exp_data = rd_data;
            rd_pend = 0;
        end else if (!rd_pend && spur_en && $urandom_range(0, 7) == 0) begin
            uart_read_rdy = 1'b1;
        end
        host_vld = hv;
        host_cmd = hc;
        uart_cmd_rdy = rdy;

        pushed = hv && (cnt < D);
        pop = uart_cmd_vld && rdy && (q.size() > 0);
        if (pop) begin
            c = q.pop_front();
            issued.push_back(c);
            hold = $urandom_range(1, 4);
            if (c[15]) begin
                rd_pend = 1;
                rd_h = cyc + 1;
                if (rd_force >= 0) begin
                    rd_k = rd_force;
                    rd_data = rd_force_data;
                end else begin
                    rd_k = ($urandom_range(0, 3) == 0) ? 0 :
                           (($urandom_range(0, 3) == 0) ? T : int'($urandom_range(1, T)));
                    rd_data = 9'($urandom_range(0, 511));
                end
                if (rd_k == 0) exp_to_cyc = rd_h + T;
            end
        end
        if (pushed) begin
            q.push_back(hc);
            last_push_edge = cyc + 1;
        end
        cnt = cnt + int'(pushed) - int'(pop);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        host_vld = 1'b0;
        uart_cmd_rdy = 1'b0;
        uart_read_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_uart_cmd_vld", uart_cmd_vld, 0);
        chk("rst_uart_cmd", uart_cmd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_host_rdy", host_rdy, 0);
        q.delete();
        cnt = 0;
        rd_pend = 0;
        exp_vld_cyc = -1;
        exp_to_cyc = -1;
        model_rsp = '0;
        hold = 0;
        obs_vld_prev = 0;
        rst_n = 1'b0;
    endtask

    initial begin
        int v0, t0, o0, base;
        logic [15:0] fc[5];
        rst_n = 1'b1; host_vld = 1'b0; host_cmd = '0;
        uart_cmd_rdy = 1'b0; uart_read_rdy = 1'b0; uart_read_data = '0;
        stall = 0; rdy_rand = 0; spur_en = 0; rd_force = -1; rd_force_data = '0;
        last_vld_rise = -100; last_push_edge = 0;
        n_vld_pulse = 0; n_to_pulse = 0; n_vld_obs = 0;
        do_reset();

        // Single write
        v0 = n_vld_pulse; t0 = n_to_pulse;
        tick(1, 16'h1234);
        repeat (3) tick(0, 16'h0);
        chk("wr_latency", last_vld_rise - last_push_edge, 2);
        repeat (10) tick(0, 16'h0);
        chk("wr_busy", obs_busy, 0);
        chk("wr_issued", issued[issued.size()-1], 16'h1234);
        chk("wr_no_rsp", (n_vld_pulse - v0) + (n_to_pulse - t0), 0);

        // Read with data
        rd_force = 3; rd_force_data = 9'h0A5;
        v0 = n_vld_pulse;
        tick(1, 16'h8055);
        repeat (12) tick(0, 16'h0);
        chk("rd_pulses", n_vld_pulse - v0, 1);
        chk("rd_data", rsp_data, 9'h0A5);

        // Read timeout
        rd_force = 0;
        v0 = n_vld_pulse; t0 = n_to_pulse;
        tick(1, 16'h8001);
        repeat (T + 10) tick(0, 16'h0);
        chk("to_pulses", n_to_pulse - t0, 1);
        chk("to_no_vld", n_vld_pulse - v0, 0);
        chk("to_busy", obs_busy, 0);

        // Read data in the same cycle as the last timeout count
        rd_force = T; rd_force_data = 9'h13C;
        v0 = n_vld_pulse; t0 = n_to_pulse;
        tick(1, 16'h8077);
        repeat (T + 10) tick(0, 16'h0);
        chk("sim_vld", n_vld_pulse - v0, 1);
        chk("sim_to", n_to_pulse - t0, 0);
        chk("sim_data", rsp_data, 9'h13C);

        // Full queue and ordering
        stall = 1; base = issued.size();
        fc = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
        for (int i = 0; i < 4; i++) tick(1, fc[i]);
        repeat (3) tick(1, fc[4]);
        chk("full_level", obs_level, 4);
        chk("full_host_rdy", obs_host_rdy, 0);
        chk("full_held", pushed, 0);
        stall = 0;
        for (int n = 0; n < 50 && !pushed; n++) tick(1, fc[4]);
        for (int n = 0; n < 200 && issued.size() < base + 5; n++) tick(0, 16'h0);
        chk("order_cnt", issued.size(), base + 5);
        if (issued.size() >= base + 5)
            for (int i = 0; i < 5; i++) chk("order", issued[base+i], fc[i]);

        // Reset while waiting for read data with two commands queued
        rd_force = 0;
        tick(1, 16'h8003); tick(1, 16'h0011); tick(1, 16'h0022);
        for (int n = 0; n < 50 && !rd_pend; n++) tick(0, 16'h0);
        tick(0, 16'h0);
        chk("mid_level", obs_level, 2);
        chk("mid_busy", obs_busy, 1);
        v0 = n_vld_pulse; t0 = n_to_pulse; o0 = n_vld_obs;
        do_reset();
        repeat (T + 10) tick(0, 16'h0);
        chk("mid_no_vld_pulse", n_vld_pulse - v0, 0);
        chk("mid_no_to_pulse", n_to_pulse - t0, 0);
        chk("mid_no_cmd_vld", n_vld_obs - o0, 0);

        // Random traffic
        rdy_rand = 1; spur_en = 1; rd_force = -1;
        for (int n = 0; n < 1500; n++) tick($urandom_range(0, 2) == 0, 16'($urandom));
        for (int n = 0; n < 3000; n++) begin
            if (q.size() == 0 && !rd_pend && cyc > exp_to_cyc && cyc > exp_vld_cyc && !obs_busy) break;
            tick(0, 16'h0);
        end
        chk("drain_q", q.size(), 0);
        chk("drain_busy", obs_busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
